pipe_debug_ctrl: RTL and testbench

PIPE_DEBUG_CTRL -- requirements
Module: pipe_debug_ctrl

---
 rtl/pipe_debug_ctrl_pkg.sv | 44 ++++
 rtl/pipe_debug_ctrl_trace_buf.sv | 85 ++++++++
 rtl/pipe_debug_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pipe_debug_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_debug_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_debug_ctrl_pkg
// Shared definitions for the pipeline debug controller:
//   - cmd_op_e      : debug command opcodes carried on cmd_op
//   - halt_cause_e  : reason recorded when the controller enters HALT
//   - dbg_state_e   : controller FSM state
//   - is_active()   : state decode for "pipeline enabled"
// ----------------------------------------------------------------------------
package pipe_debug_ctrl_pkg;

    localparam int CMD_ARG_W = 16;
    localparam int CYCLE_W   = 32;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_RUN       = 3'd1,
        OP_STEP      = 3'd2,
        OP_HALT      = 3'd3,
        OP_SET_BRK   = 3'd4,
        OP_CLR_BRK   = 3'd5,
        OP_CLR_TRACE = 3'd6,
        OP_RSVD      = 3'd7   // decoded as a no-op
    } cmd_op_e;

    typedef enum logic [1:0] {
        CAUSE_CMD       = 2'd0,
        CAUSE_BRK       = 2'd1,
        CAUSE_STEP_DONE = 2'd2,
        CAUSE_FINAL     = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } dbg_state_e;

    // The pipeline is enabled only while running freely or stepping.
    function automatic logic is_active(input dbg_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipe_debug_ctrl_trace_buf.sv
// ----------------------------------------------------------------------------
// pc_trace_buf
// Circular buffer of the most recent fetch PCs.
//   clk      : clock
//   srst     : synchronous active-high reset (clears count, pointer, read reg)
//   push     : write wr_data at the current write pointer
//   clr      : empty the buffer; a push in the same cycle is dropped
//   wr_data  : PC to record
//   rd_idx   : read index, 0 = most recent push
//   rd_data  : registered read data (1-cycle latency), 0 when rd_idx >= count
//   count    : number of valid entries, saturates at DEPTH
// ----------------------------------------------------------------------------
module pc_trace_buf
    import pipe_debug_ctrl_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     clr,
    input  logic [PC_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [PC_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic [PC_W-1:0]  rd_raw_reg;
    logic             rd_hit_reg;
    logic             push_ok;
    logic [IDX_W-1:0] rd_addr;
    logic             rd_in_range;

    assign push_ok = push && !clr;

    // Newest entry sits one below the write pointer; the subtraction wraps
    // naturally because DEPTH is a power of two.
    assign rd_addr     = wr_ptr_reg - IDX_W'(1) - rd_idx;
    assign rd_in_range = ({1'b0, rd_idx} < count_reg);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (clr) begin
            wr_ptr_next = '0;
            count_next  = '0;
        end else if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + IDX_W'(1);
            if (count_reg < (IDX_W+1)'(DEPTH)) begin
                count_next = count_reg + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            rd_hit_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            rd_hit_reg <= rd_in_range;
        end
    end

    // Storage and raw read port kept reset-free so they map onto block RAM;
    // stale contents are masked by rd_hit_reg.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        rd_raw_reg <= mem[rd_addr];
    end

    assign rd_data = rd_hit_reg ? rd_raw_reg : '0;
    assign count   = count_reg;

endmodule

// File: rtl/pipe_debug_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_debug_ctrl
// Run/step/halt debug controller for a small pipeline, with PC breakpoints,
// an enabled-cycle counter and a PC trace buffer.
//   clk, inicio      : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake; ready drops for one cycle after
//                      every accepted command
//   cmd_op/arg/slot  : opcode, STEP count or breakpoint PC, breakpoint slot
//   pc_i, final_i    : fetch PC and end-of-program flag from the pipeline
//   activo_o         : pipeline enable (RUN or STEP)
//   halted_o         : controller is in HALT
//   halt_cause_o     : why the last halt happened
//   cycle_cnt_o      : number of enabled cycles since reset (wraps)
//   trace_rd_idx     : trace read index, 0 = newest
//   trace_rd_data    : registered trace read data
//   trace_count      : valid trace entries
// ----------------------------------------------------------------------------
module pipe_debug_ctrl
    import pipe_debug_ctrl_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int N_BRK       = 4,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           inicio,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [CMD_ARG_W-1:0]           cmd_arg,
    input  logic [$clog2(N_BRK)-1:0]       cmd_slot,
    input  logic [PC_W-1:0]                pc_i,
    input  logic                           final_i,
    output logic                           activo_o,
    output logic                           halted_o,
    output logic [1:0]                     halt_cause_o,
    output logic [CYCLE_W-1:0]             cycle_cnt_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [PC_W-1:0]                trace_rd_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

    localparam int SLOT_W = $clog2(N_BRK);

    // ------------------------------------------------------------------
    // Command handshake and decode
    // ------------------------------------------------------------------
    logic     cmd_ready_reg;
    logic     cmd_accept;
    cmd_op_e  op;
    logic     run_cmd, step_cmd, halt_cmd, set_brk_cmd, clr_brk_cmd, clr_trace_cmd;

    assign op            = cmd_op_e'(cmd_op);
    assign cmd_accept    = cmd_valid && cmd_ready_reg;
    assign run_cmd       = cmd_accept && (op == OP_RUN);
    assign step_cmd      = cmd_accept && (op == OP_STEP);
    assign halt_cmd      = cmd_accept && (op == OP_HALT);
    assign set_brk_cmd   = cmd_accept && (op == OP_SET_BRK);
    assign clr_brk_cmd   = cmd_accept && (op == OP_CLR_BRK);
    assign clr_trace_cmd = cmd_accept && (op == OP_CLR_TRACE);

    // Ready is simply the inverse of "accepted last cycle".
    always_ff @(posedge clk) begin
        if (inicio) begin
            cmd_ready_reg <= 1'b1;
        end else begin
            cmd_ready_reg <= !cmd_accept;
        end
    end

    assign cmd_ready = cmd_ready_reg;

    // ------------------------------------------------------------------
    // Breakpoint slots and compare
    // ------------------------------------------------------------------
    logic [N_BRK-1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < N_BRK; gi++) begin : g_slot
            logic            en_reg;
            logic [PC_W-1:0] pc_reg;
            logic            slot_sel;

            assign slot_sel = (cmd_slot == SLOT_W'(gi));

            always_ff @(posedge clk) begin
                if (inicio) begin
                    en_reg <= 1'b0;
                    pc_reg <= '0;
                end else if (set_brk_cmd && slot_sel) begin
                    en_reg <= 1'b1;
                    pc_reg <= cmd_arg[PC_W-1:0];
                end else if (clr_brk_cmd && slot_sel) begin
                    en_reg <= 1'b0;
                end
            end

            assign slot_match[gi] = en_reg && (pc_reg == pc_i);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    dbg_state_e           state_reg, state_next;
    halt_cause_e          cause_reg, cause_next;
    logic [CMD_ARG_W-1:0] step_cnt_reg, step_cnt_next;
    logic                 skip_reg, skip_next;
    logic                 activo_reg, activo_next;
    logic                 halted_reg, halted_next;
    logic                 brk_hit;
    logic                 step_done;

    // skip_reg masks breakpoints for the first enabled cycle after a resume
    // from HALT, so a halt at a breakpoint PC does not immediately re-trigger.
    assign brk_hit   = activo_reg && !skip_reg && (|slot_match);
    // This enabled cycle is the last one of the requested step burst.
    assign step_done = (state_reg == ST_STEP) && (step_cnt_reg == CMD_ARG_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (inicio) begin
            state_reg    <= ST_IDLE;
            cause_reg    <= CAUSE_CMD;
            step_cnt_reg <= '0;
            skip_reg     <= 1'b0;
            activo_reg   <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cause_reg    <= cause_next;
            step_cnt_reg <= step_cnt_next;
            skip_reg     <= skip_next;
            activo_reg   <= activo_next;
            halted_reg   <= halted_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        cause_next    = cause_reg;
        step_cnt_next = step_cnt_reg;
        skip_next     = skip_reg;
        unique case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (run_cmd) begin
                    state_next = ST_RUN;
                    skip_next  = (state_reg == ST_HALT);
                end else if (step_cmd) begin
                    state_next    = ST_STEP;
                    skip_next     = (state_reg == ST_HALT);
                    step_cnt_next = (cmd_arg == '0) ? CMD_ARG_W'(1) : cmd_arg;
                end
            end
            ST_RUN, ST_STEP: begin
                // Every cycle here is an enabled cycle.
                skip_next = 1'b0;
                if (state_reg == ST_STEP) begin
                    step_cnt_next = step_cnt_reg - CMD_ARG_W'(1);
                end
                // Priority: FINAL > BRK > STEP_DONE > CMD
                if (final_i) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_FINAL;
                end else if (brk_hit) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_BRK;
                end else if (step_done) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_STEP_DONE;
                end else if (halt_cmd) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_CMD;
                end
            end
        endcase
    end

    // Output decode of the next state, registered alongside state_reg
    always_comb begin
        activo_next = is_active(state_next);
        halted_next = (state_next == ST_HALT);
    end

    assign activo_o     = activo_reg;
    assign halted_o     = halted_reg;
    assign halt_cause_o = cause_reg;

    // ------------------------------------------------------------------
    // Enabled-cycle counter
    // ------------------------------------------------------------------
    logic [CYCLE_W-1:0] cycle_cnt_reg;

    always_ff @(posedge clk) begin
        if (inicio) begin
            cycle_cnt_reg <= '0;
        end else if (activo_reg) begin
            cycle_cnt_reg <= cycle_cnt_reg + CYCLE_W'(1);
        end
    end

    assign cycle_cnt_o = cycle_cnt_reg;

    // ------------------------------------------------------------------
    // PC trace
    // ------------------------------------------------------------------
    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .srst    (inicio),
        .push    (activo_reg),
        .clr     (clr_trace_cmd),
        .wr_data (pc_i),
        .rd_idx  (trace_rd_idx),
        .rd_data (trace_rd_data),
        .count   (trace_count)
    );

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
module tb_pipe_debug_ctrl;
    import pipe_debug_ctrl_pkg::*;

    localparam int PC_W  = 9;
    localparam int N_BRK = 4;
    localparam int TD    = 16;

    logic        clk = 1'b0;
    logic        inicio = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic [1:0]  cmd_slot = 2'd0;
    logic [8:0]  pc_i = 9'd0;
    logic        final_i = 1'b0;
    logic        activo_o, halted_o;
    logic [1:0]  halt_cause_o;
    logic [31:0] cycle_cnt_o;
    logic [3:0]  trace_rd_idx = 4'd0;
    logic [8:0]  trace_rd_data;
    logic [4:0]  trace_count;

    pipe_debug_ctrl #(.PC_W(PC_W), .N_BRK(N_BRK), .TRACE_DEPTH(TD)) dut (
        .clk(clk), .inicio(inicio), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_slot(cmd_slot),
        .pc_i(pc_i), .final_i(final_i), .activo_o(activo_o), .halted_o(halted_o),
        .halt_cause_o(halt_cause_o), .cycle_cnt_o(cycle_cnt_o),
        .trace_rd_idx(trace_rd_idx), .trace_rd_data(trace_rd_data),
        .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    // Counters
    int checks = 0;
    int errors = 0;

    // Reference model state
    bit  bp_en_m [N_BRK];
    int  bp_pc_m [N_BRK];
    int  trace_q [$];     // front = newest
    int  cyc_total = 0;
    bit  resumed = 0;     // next session starts from HALT
    int  s_pc  [64];
    bit  s_fin [64];

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q [$];
    exp_t e;
    logic halted_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every halt entry must match the oldest predicted halt.
    always @(negedge clk) begin
        if (halted_o === 1'b1 && halted_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_halt: got halt cause %0d cycles %0d, required no halt",
                         halt_cause_o, cycle_cnt_o);
            end else begin
                e = exp_q.pop_front();
                check("halt_cause", {30'd0, halt_cause_o}, {30'd0, e.cause});
                check("halt_cycle_cnt", cycle_cnt_o, e.cnt);
            end
        end
        halted_prev = halted_o;
    end

    task automatic model_push(input int pc);
        trace_q.push_front(pc);
        if (trace_q.size() > TD) void'(trace_q.pop_back());
    endtask

    // Called #1 after a rising edge; waits (bounded) for cmd_ready.
    task automatic wait_ready();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 5) begin
            @(posedge clk); #1;
            t++;
        end
        if (cmd_ready !== 1'b1) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic issue_cmd(input logic [2:0] op, input int arg, input int slot);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg[15:0];
        cmd_slot  = slot[1:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (op)
            OP_SET_BRK:   begin bp_en_m[slot] = 1'b1; bp_pc_m[slot] = arg & 'h1ff; end
            OP_CLR_BRK:   bp_en_m[slot] = 1'b0;
            OP_CLR_TRACE: trace_q.delete();
            default: ;
        endcase
    endtask

    // One RUN or STEP session driven from s_pc/s_fin.  hc = enabled cycle in
    // which a HALT command is presented (0 = none); clr = enabled cycle in
    // which CLR_TRACE is presented (0 = none).
    task automatic run_session(input bit is_step, input int arg, input int len,
                               input int hc, input int clr);
        int n, k;
        logic [1:0] cause;
        bit b;
        n = (arg == 0) ? 1 : arg;
        k = 0;
        cause = CAUSE_CMD;
        for (int j = 1; j <= len && k == 0; j++) begin
            b = 0;
            if (!(j == 1 && resumed))
                for (int s = 0; s < N_BRK; s++)
                    if (bp_en_m[s] && bp_pc_m[s] == s_pc[j]) b = 1;
            if (s_fin[j])                 begin k = j; cause = CAUSE_FINAL; end
            else if (b)                   begin k = j; cause = CAUSE_BRK; end
            else if (is_step && j == n)   begin k = j; cause = CAUSE_STEP_DONE; end
            else if (j == hc)             begin k = j; cause = CAUSE_CMD; end
        end
        exp_q.push_back('{cause: cause, cnt: cyc_total + k});
        issue_cmd(is_step ? OP_STEP : OP_RUN, arg, 0);
        for (int j = 1; j <= k; j++) begin
            check("activo_enabled", {31'd0, activo_o}, 32'd1);
            pc_i    = s_pc[j][8:0];
            final_i = s_fin[j];
            if (j == hc || j == clr) begin
                cmd_valid = 1'b1;
                cmd_op    = (j == hc) ? OP_HALT : OP_CLR_TRACE;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (j == clr) trace_q.delete();
            else          model_push(s_pc[j]);
        end
        final_i = 1'b0;
        check("activo_after_halt", {31'd0, activo_o}, 32'd0);
        check("halted_after_halt", {31'd0, halted_o}, 32'd1);
        cyc_total += k;
        resumed = 1;
        $display("session %s arg=%0d enabled_cycles=%0d cause=%0d total=%0d",
                 is_step ? "STEP" : "RUN", arg, k, cause, cyc_total);
    endtask

    task automatic check_trace(input int idx);
        int exp_v;
        trace_rd_idx = idx[3:0];
        @(posedge clk); #1;
        exp_v = (idx < trace_q.size()) ? trace_q[idx] : 0;
        check("trace_rd_data", {23'd0, trace_rd_data}, exp_v);
        check("trace_count", {27'd0, trace_count}, trace_q.size());
        $display("trace read idx=%0d data=0x%0h count=%0d", idx, trace_rd_data, trace_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, hc, clr, arg, slot;
        bit is_step;

        // Reset with a RUN command held on the bus (must be ignored)
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        repeat (3) @(posedge clk);
        #1;
        check("rst_activo", {31'd0, activo_o}, 32'd0);
        check("rst_halted", {31'd0, halted_o}, 32'd0);
        check("rst_cause", {30'd0, halt_cause_o}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt_o, 32'd0);
        check("rst_trace_count", {27'd0, trace_count}, 32'd0);
        check("rst_trace_data", {23'd0, trace_rd_data}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        inicio    = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_activo", {31'd0, activo_o}, 32'd0);
        $display("reset done");

        // STEP 3 from IDLE
        for (int j = 1; j < 64; j++) begin s_pc[j] = 'h20 + j; s_fin[j] = 0; end
        run_session(1, 3, 3, 0, 0);
        check("step3_cycle_cnt", cycle_cnt_o, 32'd3);

        // Breakpoint at 0x010, PC stepping by 4
        issue_cmd(OP_SET_BRK, 'h010, 1);
        for (int j = 1; j < 64; j++) begin s_pc[j] = (j - 1) * 4; s_fin[j] = 0; end
        run_session(0, 0, 10, 10, 0);
        // Resume sitting on the breakpoint PC: must advance
        for (int j = 1; j < 64; j++) begin s_pc[j] = 'h10 + (j - 1) * 4; s_fin[j] = 0; end
        run_session(0, 0, 4, 4, 0);
        check_trace(2);
        check("resume_advanced_pc", {23'd0, trace_rd_data}, 32'h14);

        // FINAL and breakpoint in the same cycle
        for (int j = 1; j < 64; j++) begin s_pc[j] = 'h30 + j; s_fin[j] = 0; end
        s_pc[2] = 'h10;
        s_fin[2] = 1;
        run_session(0, 0, 5, 5, 0);

        // Back-to-back commands: HALT held right after RUN waits out the gap
        wait_ready();
        exp_q.push_back('{cause: CAUSE_CMD, cnt: cyc_total + 2});
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        @(posedge clk); #1;
        check("b2b_ready_gap", {31'd0, cmd_ready}, 32'd0);
        cmd_op = OP_HALT;
        pc_i   = 9'h100;
        @(posedge clk); #1;
        check("b2b_ready_back", {31'd0, cmd_ready}, 32'd1);
        pc_i = 9'h101;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b_ready_gap2", {31'd0, cmd_ready}, 32'd0);
        check("b2b_activo", {31'd0, activo_o}, 32'd0);
        model_push('h100);
        model_push('h101);
        cyc_total += 2;
        resumed = 1;
        $display("back-to-back RUN/HALT done total=%0d", cyc_total);

        // Trace wrap: 20 enabled cycles of PC 0..19
        issue_cmd(OP_CLR_BRK, 0, 1);
        issue_cmd(OP_CLR_TRACE, 0, 0);
        for (int j = 1; j < 64; j++) begin s_pc[j] = j - 1; s_fin[j] = 0; end
        run_session(0, 0, 20, 20, 0);
        check_trace(0);
        check("trace_idx0_const", {23'd0, trace_rd_data}, 32'd19);
        check_trace(15);
        check("trace_idx15_const", {23'd0, trace_rd_data}, 32'd4);
        check("trace_count_sat", {27'd0, trace_count}, 32'd16);

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                slot = $urandom_range(0, N_BRK - 1);
                if ($urandom_range(0, 3) == 0) issue_cmd(OP_CLR_BRK, 0, slot);
                else                           issue_cmd(OP_SET_BRK, $urandom_range(0, 15), slot);
            end
            if ($urandom_range(0, 7) == 0) issue_cmd(OP_CLR_TRACE, 0, 0);
            for (int j = 1; j < 64; j++) begin
                s_pc[j]  = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 511) : $urandom_range(0, 15);
                s_fin[j] = ($urandom_range(0, 19) == 0);
            end
            is_step = $urandom_range(0, 1);
            if (is_step) begin
                arg = $urandom_range(0, 6);
                len = (arg == 0) ? 1 : arg;
                hc  = (len >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(2, len) : 0;
                clr = 0;
            end else begin
                arg = 0;
                len = $urandom_range(4, 12);
                hc  = len;
                clr = ($urandom_range(0, 2) == 0) ? $urandom_range(2, len - 2) : 0;
            end
            run_session(is_step, arg, len, hc, clr);
            check_trace($urandom_range(0, TD - 1));
        end

        // Reset in the middle of STEP 10
        issue_cmd(OP_STEP, 10, 0);
        for (int j = 0; j < 4; j++) begin
            pc_i = 9'h1f0 + 9'(j);
            @(posedge clk); #1;
        end
        inicio = 1'b1;
        @(posedge clk); #1;
        check("midrst_activo", {31'd0, activo_o}, 32'd0);
        check("midrst_halted", {31'd0, halted_o}, 32'd0);
        check("midrst_cause", {30'd0, halt_cause_o}, 32'd0);
        check("midrst_cycle_cnt", cycle_cnt_o, 32'd0);
        check("midrst_trace_count", {27'd0, trace_count}, 32'd0);
        check("midrst_trace_data", {23'd0, trace_rd_data}, 32'd0);
        inicio = 1'b0;
        for (int s = 0; s < N_BRK; s++) bp_en_m[s] = 0;
        trace_q.delete();
        cyc_total = 0;
        resumed = 0;
        $display("reset during STEP done");

        // Recovery: STEP 2 at a PC that was a breakpoint before reset
        for (int j = 1; j < 64; j++) begin s_pc[j] = 'h10; s_fin[j] = 0; end
        run_session(1, 2, 2, 0, 0);
        check("post_rst_cycle_cnt", cycle_cnt_o, 32'd2);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
